uart_rx_frame: RTL
==================

// Module: uart_rx_frame
// PURPOSE
//  UART receiver: the downstream partner of the UART transmit path; consumes its serial 'tx' line.
//  Frame format: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
//  Samples each bit at mid-bit and deserializes the byte.
//  Presents the byte with a one-cycle valid strobe plus parity and framing error flags.
// PARAMETERS
//  CLK_FREQ  50000000  system clock frequency in Hz
//  BAUD      9600      line rate; BIT_TICKS = CLK_FREQ/BAUD (5208 at default), HALF = BIT_TICKS/2
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  asynchronous, active-low reset
//  rx          in   1  serial line, idle high; asynchronous to clk
//  parity_sel  in   1  parity mode; must match the transmitter setting for the frame
//  rx_data     out  8  last received byte; held until the next frame completes
//  rx_valid    out  1  one-cycle pulse when rx_data/parity_err/frame_err update
//  parity_err  out  1  received parity bit != expected; held with rx_data
//  frame_err   out  1  stop bit sampled 0; held with rx_data
//  rx_busy     out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset values: rx_data=8'h00, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
//    Synchronizer flops reset to 1; FSM resets to IDLE.
//  Reset mid-frame aborts the frame with no rx_valid.
//  rx passes through a 2-flop synchronizer; rx_s is the synchronized value.
//    The falling edge of rx_s is detected against one further delayed copy.
//  Baud counter: width $clog2(BIT_TICKS)+1.
//    Cleared on every state entry; increments every clk while busy.
//    Sample point = counter reaching its limit (HALF in START, BIT_TICKS-1 otherwise).
//  FSM states:
//    IDLE:   wait for a falling edge of rx_s -> START.
//            A held-low line (break) does not retrigger; a new high->low edge is required.
//    START:  sample at HALF.
//            sample=1 -> IDLE (false start, no flags, no rx_valid); sample=0 -> DATA.
//    DATA:   8 samples spaced BIT_TICKS apart.
//            Shift register shifts right, sample enters bit 7; after 8 samples bit0 = first data bit.
//            Bit index 0..7 -> PARITY after index 7.
//    PARITY: sample; expected = parity_sel ? ^shreg : ~^shreg (identical rule to the transmitter).
//            Mismatch latches an internal perr -> STOP.
//    STOP:   sample.
//            Next cycle: rx_data<=shreg, parity_err<=perr, frame_err<=~sample, rx_valid=1 for exactly one cycle -> IDLE.
//  rx_valid fires even when an error is flagged; errors clear only at the next rx_valid.
//  Latency: rx_valid rises 1 clk after the stop-bit sample.
//    This is about 10.5 bit times plus 3 clk (synchronizer + edge detect) after the start-bit falling edge.
//  parity_sel is sampled at the PARITY sample point; changing it at other times has no effect on the current frame.
//  A falling edge during STOP processing is ignored; only edges seen in IDLE start a frame.
//    Next-frame start tolerance is half a bit.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//    Each bit value is the 2-of-3 majority of rx_s sampled at the sample point -1, 0 and +1 clk.
//    The START false-start check uses the majority.
//    The decision is available at sample point +1; all later timing shifts by +1 clk.
//  UART_RX_MAJORITY_EN undefined:
//    Single sample of rx_s at the sample point; no extra latency.
// TESTING (CLK_FREQ=1000, BAUD=100 -> BIT_TICKS=10, HALF=5 for sim speed)
//  1. Frame 0xA5, parity_sel=1, correct parity bit, stop=1
//     -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, rx_busy low after.
//  2. Frame 0x3C, parity_sel=0, parity bit inverted
//     -> rx_valid, rx_data=0x3C, parity_err=1, frame_err=0.
//     Next clean frame 0x00 clears parity_err.
//  3. Frame 0xFF, stop bit driven 0 then line held low 30 clk then high
//     -> rx_valid, frame_err=1.
//     No second frame starts until the next high->low edge.
//  4. rx low glitch of 3 clk in IDLE
//     -> rx_busy pulses then returns 0; no rx_valid; outputs unchanged.
//  5. Assert rst during DATA bit 4 of frame 0x12
//     -> all outputs go to reset values at once, no rx_valid.
//     Following frame 0x5A received correctly.
//  6. Loopback: transmitter tx -> rx at default params, Tx_data=0x81, parity_sel=1
//     -> rx_data=0x81, no errors, exactly one rx_valid per tx_send.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit, sampled at mid-bit.
// Optional `UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point (+1 clk latency).
module uart_rx_frame #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_sel,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD;
  localparam int unsigned HALF      = BIT_TICKS / 2;
  localparam int unsigned CW        = $clog2(BIT_TICKS) + 1;
`ifdef UART_RX_MAJORITY_EN
  // Only START is delayed; later bits keep BIT_TICKS spacing from the shifted start.
  localparam int unsigned START_LIM = HALF + 1;
`else
  localparam int unsigned START_LIM = HALF;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nx;
  logic            rx_m, rx_s, rx_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   limit;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic            perr;
  logic            fall;
  logic            sample_now;
  logic            bit_val;

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_d2 <= 1'b1;
    else      rx_d2 <= rx_d;
  end
  assign bit_val = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
`else
  assign bit_val = rx_s;
`endif

  assign fall       = rx_d & ~rx_s;
  assign limit      = (state == START) ? CW'(START_LIM) : CW'(BIT_TICKS - 1);
  assign sample_now = (state != IDLE) && (cnt == limit);
  assign rx_busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (fall) state_nx = START;
      START:   if (sample_now) state_nx = bit_val ? IDLE : DATA;
      DATA:    if (sample_now && bit_idx == 3'd7) state_nx = PARITY;
      PARITY:  if (sample_now) state_nx = STOP;
      STOP:    if (sample_now) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state_nx != state || sample_now) begin
      cnt <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      perr    <= 1'b0;
    end else if (sample_now) begin
      unique case (state)
        START:   bit_idx <= '0;
        DATA: begin
          shreg   <= {bit_val, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        PARITY:  perr <= (bit_val != (parity_sel ? ^shreg : ~^shreg));
        default: ;
      endcase
    end
  end

  // Result registers update on the stop sample, so rx_valid is seen one clk later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_valid   <= 1'b0;
    end else if (sample_now && state == STOP) begin
      rx_data    <= shreg;
      parity_err <= perr;
      frame_err  <= ~bit_val;
      rx_valid   <= 1'b1;
    end else begin
      rx_valid   <= 1'b0;
    end
  end

endmodule
